// File: rtl/psum_accumulator.sv
// Per-lane saturating partial-sum accumulator feeding the PPU.
// A tile of K signed beats is summed per lane, then handed to a holding register that is released by ppu_done.
module psum_accumulator #(
  parameter int LANES = 16,
  parameter int IN_W  = 20,
  parameter int ACC_W = 24,
  parameter int K_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [K_W-1:0]         k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic [LANES*ACC_W-1:0] partial_sum,
  output logic                   psum_valid,
  input  logic                   ppu_done,
  output logic [LANES-1:0]       sat_flags,
  output logic                   busy
);

  typedef enum logic {ACC, PEND} state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  state_t                 state_q;
  logic [LANES*ACC_W-1:0] acc_q;
  logic [LANES*ACC_W-1:0] psum_q;
  logic [LANES*ACC_W-1:0] sum_d;
  logic [LANES-1:0]       tileSat_q;
  logic [LANES-1:0]       tileSat_d;
  logic [LANES-1:0]       satFlags_q;
  logic [K_W-1:0]         cnt_q;
  logic [K_W-1:0]         kEff_q;
  logic [K_W-1:0]         kEff_d;
  logic                   psumValid_q;
  logic                   accept;
  logic                   lastBeat;
  logic                   holdFree;
  logic signed [ACC_W:0]  laneBase;
  logic signed [ACC_W:0]  laneBeat;
  logic signed [ACC_W:0]  laneSum;

  // The first beat of a tile ignores the stale accumulator and clears the sticky saturation bits.
  always_comb begin
    accept    = in_valid && (state_q == ACC);
    holdFree  = !psumValid_q || ppu_done;
    kEff_d    = kEff_q;
    if (cnt_q == '0) begin
      kEff_d = (k_len == '0) ? K_W'(1) : k_len;
    end
    lastBeat  = (cnt_q == kEff_d - K_W'(1));
    sum_d     = '0;
    tileSat_d = '0;
    laneBase  = '0;
    laneBeat  = '0;
    laneSum   = '0;
    for (int i = 0; i < LANES; i++) begin
      laneBase = (cnt_q == '0) ? '0 : {acc_q[i*ACC_W+ACC_W-1], acc_q[i*ACC_W +: ACC_W]};
      laneBeat = {{(ACC_W+1-IN_W){in_data[i*IN_W+IN_W-1]}}, in_data[i*IN_W +: IN_W]};
      laneSum  = laneBase + laneBeat;
      tileSat_d[i] = (cnt_q != '0) && tileSat_q[i];
      if (laneSum > SAT_MAX) begin
        sum_d[i*ACC_W +: ACC_W] = SAT_MAX[ACC_W-1:0];
        tileSat_d[i]            = 1'b1;
      end else if (laneSum < SAT_MIN) begin
        sum_d[i*ACC_W +: ACC_W] = SAT_MIN[ACC_W-1:0];
        tileSat_d[i]            = 1'b1;
      end else begin
        sum_d[i*ACC_W +: ACC_W] = laneSum[ACC_W-1:0];
      end
    end
  end

  // A load into the holding register in the same cycle as ppu_done overrides the release, so valid never bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      psum_q      <= '0;
      tileSat_q   <= '0;
      satFlags_q  <= '0;
      cnt_q       <= '0;
      kEff_q      <= '0;
      psumValid_q <= 1'b0;
    end else begin
      if (psumValid_q && ppu_done) begin
        psumValid_q <= 1'b0;
      end
      case (state_q)
        ACC: begin
          if (accept) begin
            kEff_q <= kEff_d;
            if (!lastBeat) begin
              acc_q     <= sum_d;
              tileSat_q <= tileSat_d;
              cnt_q     <= cnt_q + K_W'(1);
            end else begin
              cnt_q <= '0;
              if (holdFree) begin
                psum_q      <= sum_d;
                satFlags_q  <= tileSat_d;
                psumValid_q <= 1'b1;
              end else begin
                acc_q     <= sum_d;
                tileSat_q <= tileSat_d;
                state_q   <= PEND;
              end
            end
          end
        end
        PEND: begin
          if (holdFree) begin
            psum_q      <= acc_q;
            satFlags_q  <= tileSat_q;
            psumValid_q <= 1'b1;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign in_ready    = (state_q == ACC);
  assign partial_sum = psum_q;
  assign psum_valid  = psumValid_q;
  assign sat_flags   = satFlags_q;
  assign busy        = (cnt_q != '0) || (state_q == PEND) || psumValid_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed tiles plus random traffic, scored against a per-tile arithmetic model.
// Expected tile results are queued at the last beat; a negedge monitor pops them whenever a new result is presented.
module tb_psum_accumulator;

  localparam int LANES = 16;
  localparam int IN_W  = 20;
  localparam int ACC_W = 24;
  localparam int K_W   = 8;
  localparam int DW    = LANES*ACC_W;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [LANES-1:0] sat;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [K_W-1:0]        k_len = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_data = '0;
  logic [DW-1:0]         partial_sum;
  logic                  psum_valid;
  logic                  ppu_done = 1'b0;
  logic [LANES-1:0]      sat_flags;
  logic                  busy;

  int   checks = 0;
  int   errors = 0;
  exp_t scoreQ[$];
  exp_t curExp = '0;
  bit   prevValid = 1'b0;
  bit   prevDone = 1'b0;
  bit   autoDone = 1'b0;
  int   modelSum[LANES];
  bit   modelSat[LANES];
  int   modelCnt = 0;
  int   modelK = 1;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .partial_sum(partial_sum), .psum_valid(psum_valid),
    .ppu_done(ppu_done), .sat_flags(sat_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer sums, clamped after every beat, tile length fixed by its first beat.
  task automatic modelAccept(input logic [K_W-1:0] k, input logic [LANES*IN_W-1:0] d);
    exp_t e;
    int   x;
    int   t;
    if (modelCnt == 0) begin
      modelK = (k == 0) ? 1 : int'(k);
      for (int i = 0; i < LANES; i++) begin
        modelSum[i] = 0;
        modelSat[i] = 1'b0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      x = int'($signed(d[i*IN_W +: IN_W]));
      t = modelSum[i] + x;
      if (t > 8388607) begin t = 8388607; modelSat[i] = 1'b1; end
      if (t < -8388608) begin t = -8388608; modelSat[i] = 1'b1; end
      modelSum[i] = t;
    end
    modelCnt++;
    if (modelCnt == modelK) begin
      for (int i = 0; i < LANES; i++) begin
        e.data[i*ACC_W +: ACC_W] = modelSum[i][ACC_W-1:0];
        e.sat[i] = modelSat[i];
      end
      scoreQ.push_back(e);
      modelCnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic [K_W-1:0] k, input logic [LANES*IN_W-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    k_len    = k;
    in_data  = d;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout actual=in_ready_low expected=accept");
      in_valid = 1'b0;
      return;
    end
    modelAccept(k, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseDone();
    ppu_done = 1'b1;
    @(posedge clk); #1;
    ppu_done = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [LANES*IN_W-1:0] allLanes(input int v);
    logic [LANES*IN_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = v[IN_W-1:0];
    return r;
  endfunction

  // Monitor: a fresh result appears when valid rises or when valid stays up after a done cycle.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      prevDone  = 1'b0;
    end else begin
      if (psum_valid && (!prevValid || prevDone)) begin
        if (scoreQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual=%0h expected=none", partial_sum);
        end else begin
          curExp = scoreQ.pop_front();
          checkOutput("psum_data", partial_sum, curExp.data);
          checkOutput("sat_flags", DW'(sat_flags), DW'(curExp.sat));
        end
      end else if (psum_valid) begin
        checkOutput("psum_hold", partial_sum, curExp.data);
      end else if (prevValid && !prevDone) begin
        checkOutput("valid_drop", DW'(psum_valid), DW'(1));
      end
      prevValid = psum_valid;
      prevDone  = ppu_done;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (autoDone) ppu_done = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    logic [LANES*IN_W-1:0] d;
    logic [K_W-1:0]        kr;
    int                    guard;

    $display("[TB] start");
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_psum", partial_sum, '0);
    checkOutput("reset_valid", DW'(psum_valid), '0);
    checkOutput("reset_busy", DW'(busy), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", DW'(in_ready), DW'(1));

    // Basic tile with one-cycle latency and release.
    for (int b = 0; b < 3; b++) applyStimulus(8'd4, allLanes(100));
    checkOutput("t1_not_early", DW'(psum_valid), '0);
    checkOutput("t1_busy", DW'(busy), DW'(1));
    applyStimulus(8'd4, allLanes(100));
    checkOutput("t1_latency", DW'(psum_valid), DW'(1));
    idleCycles(3);
    pulseDone();
    checkOutput("t1_release", DW'(psum_valid), '0);

    // PPU vector.
    applyStimulus(8'd2, allLanes(480758));
    applyStimulus(8'd2, allLanes(480759));
    idleCycles(1);
    pulseDone();

    // Saturation in both directions, then a clean tile clears the flags.
    d = allLanes(1);
    d[0 +: IN_W]    = 20'h7FFFF;
    d[IN_W +: IN_W] = 20'h80000;
    for (int b = 0; b < 20; b++) applyStimulus(8'd20, d);
    idleCycles(1);
    pulseDone();
    applyStimulus(8'd1, allLanes(5));
    idleCycles(1);
    pulseDone();

    // Back-pressure into the pending state.
    applyStimulus(8'd1, allLanes(7));
    applyStimulus(8'd2, allLanes(3));
    applyStimulus(8'd2, allLanes(3));
    checkOutput("t4_pend_ready", DW'(in_ready), '0);
    checkOutput("t4_pend_busy", DW'(busy), DW'(1));
    idleCycles(2);
    checkOutput("t4_still_pend", DW'(in_ready), '0);
    pulseDone();
    checkOutput("t4_valid_kept", DW'(psum_valid), DW'(1));
    checkOutput("t4_ready_back", DW'(in_ready), DW'(1));
    pulseDone();

    // Last beat coincides with release of the held tile.
    applyStimulus(8'd1, allLanes(4));
    applyStimulus(8'd3, allLanes(2));
    applyStimulus(8'd3, allLanes(2));
    ppu_done = 1'b1;
    applyStimulus(8'd3, allLanes(2));
    ppu_done = 1'b0;
    checkOutput("t5_no_bubble", DW'(psum_valid), DW'(1));
    pulseDone();
    checkOutput("t5_release", DW'(psum_valid), '0);

    // Reset discards a held tile and a partial one; k_len of zero means one beat.
    applyStimulus(8'd1, allLanes(3));
    for (int b = 0; b < 3; b++) applyStimulus(8'd4, allLanes(1));
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_psum", partial_sum, '0);
    checkOutput("t6_rst_valid", DW'(psum_valid), '0);
    checkOutput("t6_rst_sat", DW'(sat_flags), '0);
    checkOutput("t6_rst_busy", DW'(busy), '0);
    scoreQ.delete();
    modelCnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t6_ready", DW'(in_ready), DW'(1));
    for (int b = 0; b < 4; b++) applyStimulus(8'd4, allLanes(1));
    idleCycles(1);
    pulseDone();
    applyStimulus(8'd0, allLanes(9));
    checkOutput("t6_k0_single", DW'(psum_valid), DW'(1));
    pulseDone();

    // Random traffic with a randomly stalling PPU and mid-tile k_len changes.
    autoDone = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idleCycles(1);
      end else begin
        for (int i = 0; i < LANES; i++) begin
          case ($urandom_range(0, 3))
            0:       d[i*IN_W +: IN_W] = 20'h7FFFF;
            1:       d[i*IN_W +: IN_W] = 20'h80000;
            default: d[i*IN_W +: IN_W] = IN_W'($urandom());
          endcase
        end
        kr = ($urandom_range(0, 7) == 0) ? K_W'($urandom_range(0, 40)) : K_W'($urandom_range(0, 4));
        applyStimulus(kr, d);
      end
    end
    autoDone = 1'b0;
    ppu_done = 1'b0;
    guard = 0;
    while ((scoreQ.size() != 0 || psum_valid) && guard < 300) begin
      if (psum_valid) pulseDone();
      else idleCycles(1);
      guard++;
    end
    checkOutput("drain_queue", DW'(scoreQ.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
